// File: rtl/cache_pkg.sv
// Shared constants, state type and small line/address helpers for the
// cache-line-to-memory-burst adaptor.
package cache_pkg;

    localparam int LINE_W   = 256;
    localparam int BURST_W  = 64;
    localparam int BEATS    = LINE_W / BURST_W;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

    // Select beat idx of a full line.
    function automatic logic [BURST_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                      input logic [CNT_W-1:0]  idx);
        return line[BURST_W*idx +: BURST_W];
    endfunction

    // Clear the in-line byte offset so memory always sees a line-aligned address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat index within a burst. Wraps to zero on the final beat; last_o flags
// the cycle in which that final beat is accepted.
module beat_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_last_s;

    assign at_last_s = (count_q == CNT_W'(BEATS - 1));
    assign last_o    = en_i && at_last_s;
    assign count_o   = count_q;

    // Next count: clear has priority, otherwise step on each accepted beat.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            if (at_last_s) begin
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Cache line port (256 bit) to memory burst port (64 bit) adaptor.
// Every line read or write becomes a burst of BEATS beats, then a one-cycle
// resp_o pulse back to the cache. All outputs are registered.
// Optional protocol checker: define CACHELINE_ADAPTOR_CHECK_EN to enable
// the sticky err_o flag; otherwise err_o is tied low.
module cacheline_adaptor
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);

    adaptor_state_t     state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  rline_q, rline_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;

    logic [CNT_W-1:0]   cnt_s;
    logic               last_s;
    logic               clear_s;
    logic               en_s;

    // Counter is held at zero in IDLE so every burst starts from beat 0;
    // memory strobes outside a burst never move it.
    assign clear_s = (state_q == IDLE);
    assign en_s    = resp_i && ((state_q == RD_BURST) || (state_q == WR_BURST));

    beat_counter u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_s),
        .en_i    (en_s),
        .count_o (cnt_s),
        .last_o  (last_s)
    );

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rline_d = rline_q;
        wline_d = wline_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = RD_BURST;
                    addr_d  = line_align(address_i);
                end else if (write_i) begin
                    state_d = WR_BURST;
                    addr_d  = line_align(address_i);
                    wline_d = line_i;
                    burst_d = line_i[BURST_W-1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            RD_BURST: begin
                if (en_s) begin
                    rline_d[BURST_W*cnt_s +: BURST_W] = burst_i;
                    if (last_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_BURST;
                    end
                end else begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: begin
                if (en_s) begin
                    if (last_s) begin
                        state_d = DONE;
                    end else begin
                        // Present the following beat only once this one is taken.
                        burst_d = line_beat(wline_q, cnt_s + CNT_W'(1));
                    end
                end else begin
                    state_d = WR_BURST;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        read_d  = (state_d == RD_BURST);
        write_d = (state_d == WR_BURST);
        resp_d  = (state_d == DONE);
    end

    // State and registered outputs; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            rline_q <= {LINE_W{1'b0}};
            wline_q <= {LINE_W{1'b0}};
            burst_q <= {BURST_W{1'b0}};
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rline_q <= rline_d;
            wline_q <= wline_d;
            burst_q <= burst_d;
            read_q  <= read_d;
            write_q <= write_d;
            resp_q  <= resp_d;
        end
    end

    assign line_o    = rline_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef CACHELINE_ADAPTOR_CHECK_EN
    logic err_q;

    // Sticky flag for conflicting requests or stray memory strobes while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && ((read_i && write_i) || resp_i)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, stalled write, simultaneous
// request, reset mid-burst and back-to-back transactions.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
    logic         err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_err;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef CACHELINE_ADAPTOR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_err_o", err_o, 1'b0);
        chk("rst_addr", address_o, 32'h0);
        chk("rst_line", line_o, 256'h0);
        chk("rst_burst", burst_o, 64'h0);
        rst = 1'b1;
        tick();

        // ---- Read, no stalls ----
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        chk("rd_read_o", read_o, 1'b1);
        chk("rd_addr", address_o, 32'h0000_1220);
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'h1111_1111_1111_1111; tick();
        burst_i = 64'h2222_2222_2222_2222; tick();
        burst_i = 64'h3333_3333_3333_3333; tick();
        chk("rd_resp_early", resp_o, 1'b0);
        burst_i = 64'h4444_4444_4444_4444; tick();
        resp_i = 1'b0;
        chk("rd_resp", resp_o, 1'b1);
        chk("rd_read_o_done", read_o, 1'b0);
        chk("rd_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        tick();
        chk("rd_resp_one", resp_o, 1'b0);
        chk("rd_line_hold", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // ---- Write with stalls ----
        address_i = 32'h8000_004F; write_i = 1'b1;
        line_i = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        tick();
        write_i = 1'b0;
        chk("wr_write_o", write_o, 1'b1);
        chk("wr_read_o", read_o, 1'b0);
        chk("wr_addr", address_o, 32'h8000_0040);
        chk("wr_beat0", burst_o, 64'hAAAA_AAAA_AAAA_AAAA);
        resp_i = 1'b1; tick();
        chk("wr_beat1", burst_o, 64'hBBBB_BBBB_BBBB_BBBB);
        tick();
        chk("wr_beat2", burst_o, 64'hCCCC_CCCC_CCCC_CCCC);
        resp_i = 1'b0; tick();
        chk("wr_stall_a", burst_o, 64'hCCCC_CCCC_CCCC_CCCC);
        tick();
        chk("wr_stall_b", burst_o, 64'hCCCC_CCCC_CCCC_CCCC);
        chk("wr_stall_wo", write_o, 1'b1);
        resp_i = 1'b1; tick();
        chk("wr_beat3", burst_o, 64'hDDDD_DDDD_DDDD_DDDD);
        tick();
        resp_i = 1'b0;
        chk("wr_resp", resp_o, 1'b1);
        chk("wr_write_o_done", write_o, 1'b0);
        tick();
        chk("wr_resp_one", resp_o, 1'b0);

        // ---- Simultaneous read and write ----
        address_i = 32'h0000_0100; read_i = 1'b1; write_i = 1'b1;
        tick();
        read_i = 1'b0; write_i = 1'b0;
        chk("sim_read_o", read_o, 1'b1);
        chk("sim_write_o", write_o, 1'b0);
        resp_i = 1'b1;
        burst_i = 64'h0000_0000_0000_00A0; tick();
        burst_i = 64'h0000_0000_0000_00A1; tick();
        burst_i = 64'h0000_0000_0000_00A2; tick();
        burst_i = 64'h0000_0000_0000_00A3; tick();
        resp_i = 1'b0;
        chk("sim_resp", resp_o, 1'b1);
        chk("sim_line", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        chk("sim_err", err_o, exp_err);
        tick();

        // ---- Reset mid-burst ----
        address_i = 32'h0000_2000; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1;
        burst_i = 64'hDEAD_0000_0000_0001; tick();
        burst_i = 64'hDEAD_0000_0000_0002; tick();
        resp_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_read_o", read_o, 1'b0);
        chk("mid_rst_line", line_o, 256'h0);
        chk("mid_rst_err", err_o, 1'b0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_idle", read_o, 1'b0);
        address_i = 32'hABCD_EF7F; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        chk("post_rst_addr", address_o, 32'hABCD_EF60);
        resp_i = 1'b1;
        burst_i = 64'h5555_5555_5555_5555; tick();
        burst_i = 64'h6666_6666_6666_6666; tick();
        burst_i = 64'h7777_7777_7777_7777; tick();
        burst_i = 64'h8888_8888_8888_8888; tick();
        resp_i = 1'b0;
        chk("post_rst_resp", resp_o, 1'b1);
        chk("post_rst_line", line_o, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                      64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        tick();

        // ---- Back-to-back: write, then read held ----
        address_i = 32'h0000_3000; write_i = 1'b1; line_i = {64'h4, 64'h3, 64'h2, 64'h1};
        tick();
        write_i = 1'b0; read_i = 1'b1;
        chk("b2b_write_o", write_o, 1'b1);
        resp_i = 1'b1;
        tick(); tick(); tick(); tick();
        resp_i = 1'b0;
        chk("b2b_resp1", resp_o, 1'b1);
        tick();
        chk("b2b_idle_read_o", read_o, 1'b0);
        chk("b2b_idle_resp", resp_o, 1'b0);
        tick();
        read_i = 1'b0;
        chk("b2b_read_o", read_o, 1'b1);
        resp_i = 1'b1;
        burst_i = 64'h0000_0000_0000_0B00; tick();
        burst_i = 64'h0000_0000_0000_0B01; tick();
        burst_i = 64'h0000_0000_0000_0B02; tick();
        burst_i = 64'h0000_0000_0000_0B03; tick();
        resp_i = 1'b0;
        chk("b2b_resp2", resp_o, 1'b1);
        chk("b2b_line", line_o, {64'hB03, 64'hB02, 64'hB01, 64'hB00});
        tick();
        chk("b2b_end", resp_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
